// File: rtl/kws_layer_sequencer.sv
// Mask-driven layer sequencer for the KWS accelerator: launches the selected
// stages in ascending order, arbitrates the shared PSRAM port and guards each stage with a watchdog.
module kws_layer_sequencer #(
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned IDX_W      = $clog2(NUM_LAYERS),
  parameter int unsigned TIMEOUT_W  = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_LAYERS-1:0]   layer_mask,
  input  logic [TIMEOUT_W-1:0]    timeout_limit,
  input  logic [NUM_LAYERS-1:0]   layer_done,
  output logic [NUM_LAYERS-1:0]   layer_start,
  input  logic [NUM_LAYERS-1:0]   l_psram_sck,
  input  logic [NUM_LAYERS-1:0]   l_psram_ce_n,
  input  logic [4*NUM_LAYERS-1:0] l_psram_douten,
  input  logic [4*NUM_LAYERS-1:0] l_psram_dout,
  output logic                    psram_sck,
  output logic                    psram_ce_n,
  output logic [3:0]              psram_douten,
  output logic [3:0]              psram_dout,
  output logic                    busy,
  output logic [IDX_W-1:0]        cur_layer,
  output logic                    done,
  output logic                    error,
  output logic [IDX_W-1:0]        err_layer
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [TIMEOUT_W-1:0]   timer;
  logic [NUM_LAYERS-1:0]  mask_q;
  logic                   error_q;
  logic [IDX_W-1:0]       err_layer_q;

  logic [IDX_W-1:0]       first_idx;
  logic                   first_found;
  logic [IDX_W-1:0]       next_idx;
  logic                   next_found;
  logic                   port_active;

  // Lowest set bit of the incoming mask selects the first layer of a run.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!first_found && layer_mask[i]) begin
        first_idx   = IDX_W'(i);
        first_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!next_found && mask_q[i] && (i > 32'(idx))) begin
        next_idx   = IDX_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      timer       <= '0;
      mask_q      <= '0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            mask_q  <= layer_mask;
            error_q <= 1'b0;
            if (first_found) begin
              idx   <= first_idx;
              state <= S_LAUNCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          // abort beats layer_done, which beats the watchdog
          if (abort) begin
            state <= S_IDLE;
          end else if (layer_done[idx]) begin
            if (next_found) begin
              idx   <= next_idx;
              state <= S_LAUNCH;
            end else begin
              state <= S_DONE;
            end
          end else if ((timeout_limit != '0) && (timer == timeout_limit)) begin
            state <= S_ERR;
          end else if (timer != '1) begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          error_q     <= 1'b1;
          err_layer_q <= idx;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    layer_start = '0;
    if (state == S_LAUNCH) layer_start[idx] = 1'b1;
  end

  assign port_active = (state == S_LAUNCH) || (state == S_RUN);

  // Port is parked (clock low, deselected, not driving) outside LAUNCH/RUN.
  always_comb begin
    psram_sck    = 1'b0;
    psram_ce_n   = 1'b1;
    psram_douten = '0;
    psram_dout   = '0;
    if (port_active) begin
      psram_sck    = l_psram_sck[idx];
      psram_ce_n   = l_psram_ce_n[idx];
      psram_douten = l_psram_douten[{idx, 2'b00} +: 4];
      psram_dout   = l_psram_dout[{idx, 2'b00} +: 4];
    end
  end

  assign busy      = (state == S_LAUNCH) || (state == S_RUN) || (state == S_DONE);
  assign done      = (state == S_DONE);
  assign cur_layer = idx;
  assign error     = error_q;
  assign err_layer = err_layer_q;

endmodule

// File: tb/tb_kws_layer_sequencer.sv
// Scoreboard bench for kws_layer_sequencer: expected launch/done/error events
// are queued when a run is started and popped as the sequencer emits them.
module tb_kws_layer_sequencer;

  localparam int NL  = 6;
  localparam int IW  = 3;
  localparam int TW  = 20;
  localparam int EV_DONE = 100;
  localparam int EV_ERR  = 200;
  localparam int EV_NONE = 999;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [NL-1:0]   layer_mask;
  logic [TW-1:0]   timeout_limit;
  logic [NL-1:0]   layer_done;
  logic [NL-1:0]   layer_start;
  logic [NL-1:0]   l_psram_sck;
  logic [NL-1:0]   l_psram_ce_n;
  logic [4*NL-1:0] l_psram_douten;
  logic [4*NL-1:0] l_psram_dout;
  logic            psram_sck;
  logic            psram_ce_n;
  logic [3:0]      psram_douten;
  logic [3:0]      psram_dout;
  logic            busy;
  logic [IW-1:0]   cur_layer;
  logic            done;
  logic            error;
  logic [IW-1:0]   err_layer;

  logic [NL-1:0]   resp_done;
  logic [NL-1:0]   inj_done;
  assign layer_done = resp_done | inj_done;

  kws_layer_sequencer #(
    .NUM_LAYERS (NL),
    .IDX_W      (IW),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .layer_mask     (layer_mask),
    .timeout_limit  (timeout_limit),
    .layer_done     (layer_done),
    .layer_start    (layer_start),
    .l_psram_sck    (l_psram_sck),
    .l_psram_ce_n   (l_psram_ce_n),
    .l_psram_douten (l_psram_douten),
    .l_psram_dout   (l_psram_dout),
    .psram_sck      (psram_sck),
    .psram_ce_n     (psram_ce_n),
    .psram_douten   (psram_douten),
    .psram_dout     (psram_dout),
    .busy           (busy),
    .cur_layer      (cur_layer),
    .done           (done),
    .error          (error),
    .err_layer      (err_layer)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];
  int cyc = 0;

  // Control owned by the main process, read by the responder and monitor.
  int          test_id    = 0;
  int          resp_delay = 3;
  bit          resp_en    = 1'b1;
  logic [NL-1:0] hang     = '0;
  int          start_cyc  = 0;

  // Monitor-owned observations.
  int last_ev      = -1;
  int last_ls_cyc  = 0;
  int first_ls_cyc = 0;
  int done_cyc     = 0;
  int err_cyc      = 0;
  int busy_cnt     = 0;
  int act_layer    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  function automatic logic [9:0] port_sig(input int i);
    logic [31:0] v;
    v = i;
    return {v[0], v[1], 4'(15 - i), 4'(i + 1)};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int i = 0; i < NL; i++) begin
      logic [31:0] v;
      v = i;
      l_psram_sck[i]          = v[0];
      l_psram_ce_n[i]         = v[1];
      l_psram_douten[4*i +: 4] = 4'(15 - i);
      l_psram_dout[4*i +: 4]   = 4'(i + 1);
    end
  end

  // Layer model: each launched layer signals a one-cycle done resp_delay cycles later.
  initial begin
    int cd[NL];
    resp_done = '0;
    for (int i = 0; i < NL; i++) cd[i] = 0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      if (!rst_n) begin
        for (int i = 0; i < NL; i++) cd[i] = 0;
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (cd[i] > 0) begin
            cd[i]--;
            if (cd[i] == 0) resp_done[i] = 1'b1;
          end
        end
        for (int i = 0; i < NL; i++)
          if (layer_start[i] && resp_en && !hang[i]) cd[i] = resp_delay;
      end
    end
  end

  initial begin
    int  prev_test;
    bit  err_prev;
    int  e;
    int  li;
    logic [9:0] obs_sig;
    prev_test = -1;
    err_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (test_id != prev_test) begin
        prev_test = test_id;
        last_ev   = -1;
        busy_cnt  = 0;
      end
      if (layer_start != '0) begin
        check_eq("ls_onehot", $countones(layer_start), 1);
        li = 0;
        for (int i = NL - 1; i >= 0; i--) if (layer_start[i]) li = i;
        e = (sb.size() != 0) ? sb.pop_front() : EV_NONE;
        check_eq("ls_order", li, e);
        if (last_ev < 0) first_ls_cyc = cyc;
        else check_eq("ls_gap", cyc - last_ev, 4);
        last_ev     = cyc;
        last_ls_cyc = cyc;
        act_layer   = li;
      end
      if (done) begin
        e = (sb.size() != 0) ? sb.pop_front() : EV_NONE;
        check_eq("done_evt", EV_DONE, e);
        if (last_ev >= 0) check_eq("done_gap", cyc - last_ev, 4);
        last_ev  = cyc;
        done_cyc = cyc;
      end
      if (error && !err_prev) begin
        e = (sb.size() != 0) ? sb.pop_front() : EV_NONE;
        check_eq("err_evt", EV_ERR + 32'(err_layer), e);
        err_cyc = cyc;
      end
      err_prev = error;
      if (busy) busy_cnt++;
      obs_sig = {psram_sck, psram_ce_n, psram_douten, psram_dout};
      if (busy && !done) check_eq("psram_active", obs_sig, port_sig(act_layer));
      else               check_eq("psram_idle",   obs_sig, 10'b01_0000_0000);
    end
  end

  task automatic pulse_start(input logic [NL-1:0] m);
    @(negedge clk);
    start      = 1'b1;
    layer_mask = m;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sb(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ls"},   layer_start, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_cur"},  cur_layer, 0);
    check_eq({tag, "_err"},  error, 0);
    check_eq({tag, "_errl"}, err_layer, 0);
    check_eq({tag, "_port"}, {psram_sck, psram_ce_n, psram_douten, psram_dout}, 10'b01_0000_0000);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    layer_mask    = '0;
    timeout_limit = '0;
    inj_done      = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All six layers in order.
    test_id = 1;
    for (int i = 0; i < NL; i++) sb.push_back(i);
    sb.push_back(EV_DONE);
    pulse_start(6'b111111);
    wait_sb("all", 200);
    check_eq("all_launch_lat", first_ls_cyc - start_cyc, 1);
    repeat (2) @(negedge clk);
    check_eq("all_busy_after", busy, 0);
    check_eq("all_error", error, 0);

    // Sparse mask.
    test_id = 2;
    sb.push_back(0); sb.push_back(2); sb.push_back(5); sb.push_back(EV_DONE);
    pulse_start(6'b100101);
    wait_sb("sparse", 200);
    repeat (2) @(negedge clk);
    check_eq("sparse_cur", cur_layer, 5);

    // Empty mask: straight to DONE.
    test_id = 3;
    sb.push_back(EV_DONE);
    pulse_start(6'b000000);
    wait_sb("empty", 20);
    repeat (3) @(negedge clk);
    check_eq("empty_done_lat_ok", ((done_cyc - start_cyc) >= 1) && ((done_cyc - start_cyc) <= 2), 1);
    check_eq("empty_busy_cycles", busy_cnt, 1);

    // Watchdog: layer 1 never completes.
    test_id = 4;
    timeout_limit = 4;
    hang = 6'b000010;
    sb.push_back(0); sb.push_back(1); sb.push_back(EV_ERR + 1);
    pulse_start(6'b000011);
    wait_sb("wdog", 200);
    repeat (3) @(negedge clk);
    check_eq("wdog_error", error, 1);
    check_eq("wdog_err_layer", err_layer, 1);
    check_eq("wdog_latency", err_cyc - last_ls_cyc, 7);
    check_eq("wdog_busy", busy, 0);
    hang = '0;
    timeout_limit = '0;
    test_id = 5;
    sb.push_back(0); sb.push_back(EV_DONE);
    pulse_start(6'b000001);
    check_eq("restart_clears_err", error, 0);
    wait_sb("restart", 100);
    repeat (2) @(negedge clk);

    // abort coincident with the active layer's done.
    test_id = 6;
    resp_en = 1'b0;
    sb.push_back(0);
    pulse_start(6'b000111);
    @(negedge clk);
    inj_done = 6'b000001;
    abort    = 1'b1;
    @(negedge clk);
    inj_done = '0;
    abort    = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_sb_empty", sb.size(), 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_error", error, 0);
    sb.delete();
    resp_en = 1'b1;

    // Spurious done from an inactive layer and start/mask changes mid-run.
    test_id = 7;
    sb.push_back(1); sb.push_back(3); sb.push_back(EV_DONE);
    pulse_start(6'b001010);
    @(negedge clk);
    inj_done   = 6'b001000;
    start      = 1'b1;
    layer_mask = 6'b111111;
    @(negedge clk);
    inj_done = '0;
    start    = 1'b0;
    wait_sb("spur", 200);
    repeat (2) @(negedge clk);
    check_eq("spur_busy", busy, 0);

    // Asynchronous reset mid-run.
    test_id = 8;
    hang = '1;
    sb.push_back(0);
    pulse_start(6'b111111);
    repeat (2) @(negedge clk);
    check_eq("prerst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hang  = '0;
    repeat (2) @(negedge clk);

    // Sequencer still usable after reset.
    test_id = 9;
    sb.push_back(5); sb.push_back(EV_DONE);
    pulse_start(6'b100000);
    wait_sb("post_rst", 100);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
